// File: rtl/obs_slot_sched.sv
// obs_slot_sched -- obstacle slot scheduler for the VGA shooter.
//
// Owns NUM_SLOTS obstacle slots. Spawns a new obstacle every SPAWN_GAP
// frame ticks into the lowest free slot, moves active obstacles down by
// BASE_V+level px per tick, and retires them on a hit or at the bottom.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   run          high during PLAY; low clears every slot synchronously
//   tick         one-cycle frame tick
//   level        current level 0..3 (adds to vertical speed)
//   rnd          free-running LFSR value, source of spawn x
//   hit_valid    one-cycle hit request for slot hit_slot
//   hit_ack      one-cycle pulse: hit accepted (slot was active)
//   act          per-slot active flag
//   obs_x/obs_y  packed 10-bit left/top edge per slot, slot i at [10i+9:10i]
//   miss_mask    one-cycle pulse, slots retired at the bottom this tick
//   spawn_pulse  one-cycle pulse when a spawn occurs
//
// Optional build macro OBS_DRIFT_EN: obstacles also drift 1 px per tick
// horizontally, bouncing off the screen edges.

module obs_slot_sched #(
    parameter int NUM_SLOTS = 4,
    parameter int MAX_X     = 640,
    parameter int MAX_Y     = 480,
    parameter int OBS_SIZE  = 20,
    parameter int SPAWN_GAP = 60,
    parameter int BASE_V    = 2,
    localparam int SW       = $clog2(NUM_SLOTS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    tick,
    input  logic [1:0]              level,
    input  logic [9:0]              rnd,
    input  logic                    hit_valid,
    input  logic [SW-1:0]           hit_slot,
    output logic                    hit_ack,
    output logic [NUM_SLOTS-1:0]    act,
    output logic [10*NUM_SLOTS-1:0] obs_x,
    output logic [10*NUM_SLOTS-1:0] obs_y,
    output logic [NUM_SLOTS-1:0]    miss_mask,
    output logic                    spawn_pulse
);

    localparam int XL = MAX_X - OBS_SIZE;   // rightmost legal left edge
    localparam int YL = MAX_Y - OBS_SIZE;   // lowest legal top edge
    localparam int GW = $clog2(SPAWN_GAP + 1);

    logic [GW-1:0]           gap_cnt, gap_d;
    logic [NUM_SLOTS-1:0]    act_d, miss_d, hit_vec;
    logic [10*NUM_SLOTS-1:0] obs_x_d, obs_y_d;
    logic                    hit_ack_d, spawn_d, found;
    logic [9:0]              vel, rnd_clip;
    logic [10:0]             ysum;

`ifdef OBS_DRIFT_EN
    logic [NUM_SLOTS-1:0]    dir, dir_d;    // 1 = moving right
`endif

    assign vel      = 10'(BASE_V) + {8'd0, level};
    // Fold values beyond the right edge back into range with one subtract.
    assign rnd_clip = (rnd <= 10'(XL)) ? rnd : rnd - 10'(XL + 1);

    always_comb begin
        act_d     = act;
        obs_x_d   = obs_x;
        obs_y_d   = obs_y;
        gap_d     = gap_cnt;
        miss_d    = '0;
        hit_ack_d = 1'b0;
        spawn_d   = 1'b0;
        found     = 1'b0;
        ysum      = '0;
        hit_vec   = '0;
`ifdef OBS_DRIFT_EN
        dir_d     = dir;
`endif
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            hit_vec[i] = hit_valid && (hit_slot == SW'(i)) && act[i];
        end

        if (!run) begin
            act_d   = '0;
            obs_x_d = '0;
            obs_y_d = '0;
            gap_d   = '0;
`ifdef OBS_DRIFT_EN
            dir_d   = '0;
`endif
        end else begin
            hit_ack_d = |hit_vec;
            act_d     = act & ~hit_vec;
            if (tick) begin
                // Motion only for slots active at the start of the cycle
                // and not hit now: a hit overrides both motion and miss.
                for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                    if (act[i] && !hit_vec[i]) begin
                        ysum = {1'b0, obs_y[10*i +: 10]} + {1'b0, vel};
                        if (ysum > 11'(YL)) begin
                            act_d[i]  = 1'b0;
                            miss_d[i] = 1'b1;
                        end else begin
                            obs_y_d[10*i +: 10] = ysum[9:0];
`ifdef OBS_DRIFT_EN
                            if (dir[i]) begin
                                if (obs_x[10*i +: 10] == 10'(XL)) dir_d[i] = 1'b0;
                                else obs_x_d[10*i +: 10] = obs_x[10*i +: 10] + 10'd1;
                            end else begin
                                if (obs_x[10*i +: 10] == '0) dir_d[i] = 1'b1;
                                else obs_x_d[10*i +: 10] = obs_x[10*i +: 10] - 10'd1;
                            end
`endif
                        end
                    end
                end
                // Free slots are judged from act at the start of the cycle,
                // so a slot being hit right now cannot be reused yet.
                if (gap_cnt == '0) begin
                    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                        if (!act[i] && !found) begin
                            found               = 1'b1;
                            act_d[i]            = 1'b1;
                            obs_x_d[10*i +: 10] = rnd_clip;
                            obs_y_d[10*i +: 10] = '0;
`ifdef OBS_DRIFT_EN
                            dir_d[i]            = rnd[0];
`endif
                        end
                    end
                    if (found) begin
                        gap_d   = GW'(SPAWN_GAP - 1);
                        spawn_d = 1'b1;
                    end
                end else begin
                    gap_d = gap_cnt - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act         <= '0;
            obs_x       <= '0;
            obs_y       <= '0;
            gap_cnt     <= '0;
            hit_ack     <= 1'b0;
            miss_mask   <= '0;
            spawn_pulse <= 1'b0;
`ifdef OBS_DRIFT_EN
            dir         <= '0;
`endif
        end else begin
            act         <= act_d;
            obs_x       <= obs_x_d;
            obs_y       <= obs_y_d;
            gap_cnt     <= gap_d;
            hit_ack     <= hit_ack_d;
            miss_mask   <= miss_d;
            spawn_pulse <= spawn_d;
`ifdef OBS_DRIFT_EN
            dir         <= dir_d;
`endif
        end
    end

endmodule
